// File: rtl/mem_ctrl_if.sv
// Cache-side request/response channels and main-memory port of mem_ctrl.
interface mem_ctrl_if #(
  parameter int unsigned BADDR_BITS = 29,
  parameter int unsigned BLOCK_BITS = 64
);
  logic                  icache_req_valid;
  logic [BADDR_BITS-1:0] icache_req_block_addr;
  logic                  icache_req_ready;
  logic                  icache_flush;
  logic                  icache_resp_valid;
  logic [BLOCK_BITS-1:0] icache_resp_block_data;

  logic                  dcache_req_valid;
  logic                  dcache_req_type;
  logic [BADDR_BITS-1:0] dcache_req_block_addr;
  logic [BLOCK_BITS-1:0] dcache_req_block_data;
  logic                  dcache_req_ready;
  logic                  dcache_resp_valid;
  logic [BLOCK_BITS-1:0] dcache_resp_block_data;

  logic                  mem_en;
  logic                  mem_we;
  logic [BADDR_BITS-1:0] mem_addr;
  logic [BLOCK_BITS-1:0] mem_wdata;
  logic [BLOCK_BITS-1:0] mem_rdata;

  // Controller side.
  modport slave (
    input  icache_req_valid, icache_req_block_addr, icache_flush,
    output icache_req_ready, icache_resp_valid, icache_resp_block_data,
    input  dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
    output dcache_req_ready, dcache_resp_valid, dcache_resp_block_data,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Caches and main memory side.
  modport master (
    output icache_req_valid, icache_req_block_addr, icache_flush,
    input  icache_req_ready, icache_resp_valid, icache_resp_block_data,
    output dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
    input  dcache_req_ready, dcache_resp_valid, dcache_resp_block_data,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single-outstanding main-memory controller arbitrating icache (priority) and dcache.
module mem_ctrl #(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned BLOCK_BITS  = 64,
  parameter int unsigned BADDR_BITS  = 29
) (
  input  logic      clk,
  input  logic      rst_aL,
  mem_ctrl_if.slave bus
);

  localparam int unsigned CNT_BITS = 4;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MEM_LATENCY - 32'd1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state, state_nxt;
  logic [CNT_BITS-1:0]   cnt, cnt_nxt;
  logic                  req_dc, req_dc_nxt;
  logic                  req_we, req_we_nxt;
  logic [BADDR_BITS-1:0] req_addr, req_addr_nxt;
  logic [BLOCK_BITS-1:0] req_wdata, req_wdata_nxt;
  logic                  squash, squash_nxt;

  // State, wait counter, captured request and squash flag.
  always_ff @(posedge clk) begin
    if (rst_aL) begin
      state     <= IDLE;
      cnt       <= '0;
      req_dc    <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      squash    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_dc    <= req_dc_nxt;
      req_we    <= req_we_nxt;
      req_addr  <= req_addr_nxt;
      req_wdata <= req_wdata_nxt;
      squash    <= squash_nxt;
    end
  end

  // Arbitration, latency countdown, memory strobe and response pulse.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    req_dc_nxt    = req_dc;
    req_we_nxt    = req_we;
    req_addr_nxt  = req_addr;
    req_wdata_nxt = req_wdata;
    squash_nxt    = squash;

    bus.icache_req_ready       = 1'b0;
    bus.icache_resp_valid      = 1'b0;
    bus.icache_resp_block_data = '0;
    bus.dcache_req_ready       = 1'b0;
    bus.dcache_resp_valid      = 1'b0;
    bus.dcache_resp_block_data = '0;
    bus.mem_en                 = 1'b0;
    bus.mem_we                 = 1'b0;
    bus.mem_addr               = '0;
    bus.mem_wdata              = '0;

    case (state)
      IDLE: begin
        bus.icache_req_ready = 1'b1;
        bus.dcache_req_ready = ~bus.icache_req_valid;
        squash_nxt           = 1'b0;
        if (bus.icache_req_valid) begin
          req_dc_nxt    = 1'b0;
          req_we_nxt    = 1'b0;
          req_addr_nxt  = bus.icache_req_block_addr;
          req_wdata_nxt = '0;
          cnt_nxt       = CNT_LOAD;
          state_nxt     = BUSY;
        end else if (bus.dcache_req_valid) begin
          req_dc_nxt    = 1'b1;
          req_we_nxt    = bus.dcache_req_type;
          req_addr_nxt  = bus.dcache_req_block_addr;
          req_wdata_nxt = bus.dcache_req_type ? bus.dcache_req_block_data : '0;
          cnt_nxt       = CNT_LOAD;
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (!req_dc && bus.icache_flush) squash_nxt = 1'b1;
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_BITS'(1);
        end else begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = req_we;
          bus.mem_addr  = req_addr;
          bus.mem_wdata = req_wdata;
          state_nxt     = RESP;
        end
      end
      RESP: begin
        // A flush arriving in the response cycle itself still suppresses the pulse.
        if (req_dc) begin
          bus.dcache_resp_valid      = 1'b1;
          bus.dcache_resp_block_data = req_we ? '0 : bus.mem_rdata;
        end else if (!(squash || bus.icache_flush)) begin
          bus.icache_resp_valid      = 1'b1;
          bus.icache_resp_block_data = bus.mem_rdata;
        end
        squash_nxt = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Reset forces every output low immediately, ahead of the clock edge.
    if (rst_aL) begin
      bus.icache_req_ready       = 1'b0;
      bus.icache_resp_valid      = 1'b0;
      bus.icache_resp_block_data = '0;
      bus.dcache_req_ready       = 1'b0;
      bus.dcache_resp_valid      = 1'b0;
      bus.dcache_resp_block_data = '0;
      bus.mem_en                 = 1'b0;
      bus.mem_we                 = 1'b0;
      bus.mem_addr               = '0;
      bus.mem_wdata              = '0;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: random cache traffic against a memory/latency model.
module tb_mem_ctrl;
  localparam int unsigned L  = 4;
  localparam int unsigned AW = 29;
  localparam int unsigned DW = 64;

  logic clk;
  logic rst_aL;

  mem_ctrl_if #(.BADDR_BITS(AW), .BLOCK_BITS(DW)) bus ();

  mem_ctrl #(.MEM_LATENCY(L), .BLOCK_BITS(DW), .BADDR_BITS(AW)) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic ic; logic squash; logic [DW-1:0] data; } resp_t;
  typedef struct { int due; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } acc_t;

  resp_t           resp_q[$];
  acc_t            acc_q[$];
  logic [DW-1:0]   ref_m [logic [AW-1:0]];
  logic [DW-1:0]   phys  [logic [AW-1:0]];
  logic [AW-1:0]   pool  [16];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int free_cyc = 0;
  int cur_start = 0;
  logic cur_ic = 1'b0;
  logic pend_wr = 1'b0;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_old;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endfunction

  // Main memory: samples the strobe mid-cycle, returns read data the following cycle.
  initial begin : memory
    logic en, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk); #3;
      en = bus.mem_en; we = bus.mem_we; a = bus.mem_addr; d = bus.mem_wdata;
      @(posedge clk); #1;
      if (en && we) phys[a] = d;
      if (en && !we) bus.mem_rdata = phys.exists(a) ? phys[a] : '0;
      else           bus.mem_rdata = {$urandom, $urandom};
    end
  end

  // Monitor: pops expected memory accesses and responses when they fall due.
  initial begin : monitor
    acc_t a;
    resp_t r;
    forever begin
      @(negedge clk); #2;
      if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
        a = acc_q.pop_front();
        chk("mem_en", 64'(bus.mem_en), 64'(1'b1));
        chk("mem_we", 64'(bus.mem_we), 64'(a.we));
        chk("mem_addr", 64'(bus.mem_addr), 64'(a.addr));
        if (a.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(a.wdata));
      end else begin
        chk("mem_quiet", 64'({bus.mem_en, bus.mem_we, |bus.mem_addr, |bus.mem_wdata}), 64'(0));
      end
      if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
        r = resp_q.pop_front();
        chk("ic_resp_valid", 64'(bus.icache_resp_valid), 64'(r.ic && !r.squash));
        chk("dc_resp_valid", 64'(bus.dcache_resp_valid), 64'(!r.ic));
        if (r.ic) begin
          if (!r.squash) chk("ic_resp_data", 64'(bus.icache_resp_block_data), 64'(r.data));
          chk("dc_resp_data_idle", 64'(bus.dcache_resp_block_data), 64'(0));
        end else begin
          chk("dc_resp_data", 64'(bus.dcache_resp_block_data), 64'(r.data));
          chk("ic_resp_data_idle", 64'(bus.icache_resp_block_data), 64'(0));
        end
      end else begin
        chk("resp_quiet", 64'({bus.icache_resp_valid, bus.dcache_resp_valid,
                               |bus.icache_resp_block_data, |bus.dcache_resp_block_data}), 64'(0));
      end
    end
  end

  // One cycle of stimulus; model decides readiness, handshakes and expected results.
  task automatic drive(input logic iv, input logic [AW-1:0] ia, input logic fl,
                       input logic dv, input logic dt, input logic [AW-1:0] da,
                       input logic [DW-1:0] dd, output logic ihs, output logic dhs);
    logic idle;
    resp_t r;
    @(negedge clk);
    rst_aL                    = 1'b0;
    bus.icache_req_valid      = iv;
    bus.icache_req_block_addr = iv ? ia : AW'($urandom);
    bus.icache_flush          = fl;
    bus.dcache_req_valid      = dv;
    bus.dcache_req_type       = dv ? dt : 1'($urandom);
    bus.dcache_req_block_addr = dv ? da : AW'($urandom);
    bus.dcache_req_block_data = dv ? dd : {$urandom, $urandom};
    #1;
    idle = (cyc >= free_cyc);
    if (fl && cur_ic && cyc > cur_start && cyc <= cur_start + int'(L) + 1 && resp_q.size() > 0) begin
      r = resp_q.pop_back();
      r.squash = 1'b1;
      resp_q.push_back(r);
    end
    chk("ic_ready", 64'(bus.icache_req_ready), 64'(idle));
    chk("dc_ready", 64'(bus.dcache_req_ready), 64'(idle && !iv));
    ihs = idle && iv;
    dhs = idle && dv && !iv;
    if (ihs) begin
      resp_q.push_back('{cyc + int'(L) + 1, 1'b1, 1'b0, ref_m[ia]});
      acc_q.push_back('{cyc + int'(L), 1'b0, ia, '0});
      pend_wr = 1'b0;
    end else if (dhs) begin
      if (dt) begin
        pend_wr = 1'b1; pend_a = da; pend_old = ref_m[da];
        ref_m[da] = dd;
        resp_q.push_back('{cyc + int'(L) + 1, 1'b0, 1'b0, '0});
        acc_q.push_back('{cyc + int'(L), 1'b1, da, dd});
      end else begin
        pend_wr = 1'b0;
        resp_q.push_back('{cyc + int'(L) + 1, 1'b0, 1'b0, ref_m[da]});
        acc_q.push_back('{cyc + int'(L), 1'b0, da, '0});
      end
    end
    if (ihs || dhs) begin
      cur_ic    = ihs;
      cur_start = cyc;
      free_cyc  = cyc + int'(L) + 2;
    end
  endtask

  task automatic nop();
    logic ih, dh;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, ih, dh);
  endtask

  // Reset cycles with all requests asserted; outputs must be forced low.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_aL = 1'b1;
      bus.icache_req_valid      = 1'b1;
      bus.icache_req_block_addr = AW'($urandom);
      bus.icache_flush          = 1'($urandom);
      bus.dcache_req_valid      = 1'b1;
      bus.dcache_req_type       = 1'($urandom);
      bus.dcache_req_block_addr = AW'($urandom);
      bus.dcache_req_block_data = {$urandom, $urandom};
      #1;
      if (pend_wr && cyc <= cur_start + int'(L)) ref_m[pend_a] = pend_old;
      pend_wr = 1'b0;
      resp_q.delete();
      acc_q.delete();
      free_cyc = 0;
      cur_ic   = 1'b0;
      chk("rst_outputs", 64'({bus.icache_req_ready, bus.dcache_req_ready, bus.icache_resp_valid,
                              bus.dcache_resp_valid, bus.mem_en, bus.mem_we, |bus.mem_addr,
                              |bus.mem_wdata, |bus.icache_resp_block_data,
                              |bus.dcache_resp_block_data}), 64'(0));
    end
  endtask

  task automatic send_ic(input logic [AW-1:0] a);
    logic ih, dh;
    int n;
    ih = 1'b0; n = 0;
    while (!ih && n < 40) begin
      drive(1'b1, a, 1'b0, 1'b0, 1'b0, '0, '0, ih, dh);
      n++;
    end
    chk("ic_hs_bound", 64'(ih), 64'(1'b1));
  endtask

  task automatic send_dc(input logic t, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic ih, dh;
    int n;
    dh = 1'b0; n = 0;
    while (!dh && n < 40) begin
      drive(1'b0, '0, 1'b0, 1'b1, t, a, d, ih, dh);
      n++;
    end
    chk("dc_hs_bound", 64'(dh), 64'(1'b1));
  endtask

  initial begin : stimulus
    logic ih, dh;
    logic ic_pend, dc_pend, dc_t;
    logic [AW-1:0] ic_a, dc_a;
    logic [DW-1:0] dc_d, d, old;

    rst_aL = 1'b1;
    bus.icache_req_valid = 1'b0; bus.icache_req_block_addr = '0; bus.icache_flush = 1'b0;
    bus.dcache_req_valid = 1'b0; bus.dcache_req_type = 1'b0;
    bus.dcache_req_block_addr = '0; bus.dcache_req_block_data = '0;
    for (int i = 0; i < 16; i++) begin
      pool[i] = (i == 0) ? AW'(32'h10) : (i == 1) ? AW'(32'h20) : AW'($urandom);
      d = {$urandom, $urandom};
      ref_m[pool[i]] = d;
      phys[pool[i]]  = d;
    end
    ref_m[pool[0]] = 64'hDEADBEEF_00000013;
    phys[pool[0]]  = 64'hDEADBEEF_00000013;

    do_reset(3);

    // Icache read of block 0x10.
    send_ic(pool[0]);
    repeat (L + 1) nop();

    // Simultaneous requests: icache first, dcache held until controller idles.
    drive(1'b1, pool[4], 1'b0, 1'b1, 1'b0, pool[5], '0, ih, dh);
    send_dc(1'b0, pool[5], '0);
    repeat (L + 1) nop();

    // Dcache write to 0x20, then read it back.
    send_dc(1'b1, pool[1], 64'h1122334455667788);
    send_dc(1'b0, pool[1], '0);
    repeat (L + 1) nop();

    // Flush two cycles after an icache handshake; next icache request at T+6.
    send_ic(pool[2]);
    nop();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, ih, dh);
    repeat (3) nop();
    send_ic(pool[6]);
    repeat (L + 1) nop();

    // Reset two cycles into a dcache write aborts it.
    old = ref_m[pool[3]];
    send_dc(1'b1, pool[3], 64'hA5A5_5A5A_0F0F_F0F0);
    nop();
    do_reset(1);
    nop();
    chk("abort_no_write", 64'(phys[pool[3]]), 64'(old));

    // Randomized traffic with flushes and occasional resets.
    ic_pend = 1'b0; dc_pend = 1'b0; dc_t = 1'b0; ic_a = '0; dc_a = '0; dc_d = '0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1 + int'($urandom_range(0, 1)));
      end else begin
        if (!ic_pend && $urandom_range(0, 3) == 0) begin
          ic_pend = 1'b1; ic_a = pool[$urandom_range(0, 15)];
        end
        if (!dc_pend && $urandom_range(0, 2) == 0) begin
          dc_pend = 1'b1; dc_t = 1'($urandom);
          dc_a = pool[$urandom_range(0, 15)]; dc_d = {$urandom, $urandom};
        end
        drive(ic_pend, ic_a, ($urandom_range(0, 9) == 0), dc_pend, dc_t, dc_a, dc_d, ih, dh);
        if (ih) ic_pend = 1'b0;
        if (dh) dc_pend = 1'b0;
      end
    end

    repeat (L + 3) nop();
    chk("drain_resp", 64'(resp_q.size()), 64'(0));
    chk("drain_acc", 64'(acc_q.size()), 64'(0));
    for (int i = 0; i < 16; i++) chk("mem_image", 64'(phys[pool[i]]), 64'(ref_m[pool[i]]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL use one clock, clk, and one reset, rst_aL; reset is synchronous and active-high (asserted = 1).
REQ-002 SHALL have parameter MEM_LATENCY, default 4, meaning wait cycles before the main-memory access (legal range 1..15).
REQ-003 SHALL have parameter BLOCK_BITS, default 64, meaning block data width (two 32-bit instructions).
REQ-004 SHALL have parameter BADDR_BITS, default 29, meaning block address width (byte address bits 31:3).
REQ-005 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  clock
- rst_aL  in  1  sync active-high reset
- icache_req_valid  in  1  icache miss request
- icache_req_block_addr  in  BADDR_BITS  icache block address
- icache_req_ready  out  1  controller accepts icache request
- icache_flush  in  1  fetch redirect; squash pending icache response
- icache_resp_valid  out  1  icache fill data valid (1-cycle pulse)
- icache_resp_block_data  out  BLOCK_BITS  icache fill data
- dcache_req_valid  in  1  dcache request
- dcache_req_type  in  1  0 = read, 1 = write
- dcache_req_block_addr  in  BADDR_BITS  dcache block address
- dcache_req_block_data  in  BLOCK_BITS  write-back data
- dcache_req_ready  out  1  controller accepts dcache request
- dcache_resp_valid  out  1  read data / write ack (1-cycle pulse)
- dcache_resp_block_data  out  BLOCK_BITS  dcache read data (0 for write ack)
- mem_en  out  1  main-memory access strobe
- mem_we  out  1  main-memory write enable
- mem_addr  out  BADDR_BITS  main-memory block address
- mem_wdata  out  BLOCK_BITS  main-memory write data
- mem_rdata  in  BLOCK_BITS  main-memory read data, valid the cycle after mem_en with mem_we = 0

Function
REQ-006 SHALL implement FSM states IDLE, BUSY, RESP; one transaction in flight at most.
REQ-007 In IDLE, icache_req_ready SHALL be 1; dcache_req_ready SHALL be 1 only when icache_req_valid = 0. In BUSY/RESP both readies SHALL be 0.
REQ-008 Simultaneous valid requests in IDLE: icache SHALL win; the dcache request waits, no loss.
REQ-009 On handshake (valid & ready at a clock edge), SHALL register requester, type (icache always read), address, write data; load a down-counter with MEM_LATENCY-1; go to BUSY.
REQ-010 In BUSY with counter != 0, SHALL decrement; with counter == 0, SHALL assert mem_en = 1 for exactly that cycle, with mem_we/mem_addr/mem_wdata from the registered request, then go to RESP.
REQ-011 mem_en, mem_we SHALL be 0 in every other cycle; mem_addr/mem_wdata SHALL be 0 when mem_en = 0.
REQ-012 In RESP, SHALL pulse the granted requester's resp_valid for one cycle, with resp_block_data = mem_rdata for reads, 0 for writes, then return to IDLE.
REQ-013 Latency: handshake at edge T SHALL yield resp_valid in cycle T+MEM_LATENCY+1; next request SHALL be acceptable in the cycle after RESP.
REQ-014 Non-granted requester's resp_valid and resp_block_data SHALL be 0.
REQ-015 icache_flush = 1 at any cycle while an icache transaction is in BUSY or RESP SHALL set a squash flag; the transaction SHALL still complete with unchanged timing, but icache_resp_valid SHALL stay 0 for it. The flag SHALL clear on return to IDLE.
REQ-016 icache_flush in IDLE SHALL have no effect and SHALL not block an icache handshake in the same cycle.
REQ-017 icache_flush SHALL never affect dcache transactions.
REQ-018 Request inputs SHALL be ignored outside IDLE; changes to them after handshake SHALL not affect the transaction in flight.

Reset
REQ-019 While rst_aL = 1, all outputs SHALL be 0 combinationally (mem_en, mem_we, both readies, both resp_valids, all data/address outputs).
REQ-020 After a reset edge, state SHALL be IDLE, counter 0, squash flag 0, registered request 0.
REQ-021 Reset asserted mid-transaction (BUSY or RESP) SHALL abort it: no memory write, no response pulse afterward.

Verification
REQ-022 Icache read, MEM_LATENCY = 4, addr 0x0000010, mem returns 0xDEADBEEF_00000013 -> mem_en exactly once at T+4 with mem_we = 0, icache_resp_valid at T+5 with that data.
REQ-023 icache and dcache valid together in IDLE -> icache served first; dcache_req_ready = 0 until RESP ends; dcache handshake the cycle after, its response MEM_LATENCY+1 cycles later.
REQ-024 Dcache write addr 0x0000020, data 0x1122334455667788 -> mem_en = mem_we = 1 once with that addr/data, dcache_resp_valid pulse with data 0.
REQ-025 icache_flush pulsed at T+2 of an icache read -> mem_en still at T+4, icache_resp_valid stays 0 at T+5, next icache request accepted at T+6.
REQ-026 rst_aL = 1 at T+2 of a dcache write -> mem_en never asserted, no resp pulse, IDLE with icache_req_ready = 1 the cycle after reset deasserts.
